// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path.
package spi_pkg;

    localparam int SpiByteW         = 8;
    localparam int SpiMinSyncStages = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_rx_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead synchronous FIFO with valid/ready on both sides; a full FIFO still accepts
// a write in a cycle where the head is being popped.
module spi_rx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full     = (r_count == (PtrW+1)'(Depth));
    assign rd_valid_o = (r_count != '0);
    assign wr_ready_o = ~w_full | rd_ready_i;
    assign w_push     = wr_valid_i & wr_ready_o;
    assign w_pop      = rd_valid_o & rd_ready_i;
    // Data is forced to zero while empty so the output is clean straight out of reset.
    assign rd_data_o  = rd_valid_o ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only SPI target: synchronises SCLK/CS/MOSI into clk_i and deserialises MSB-first bytes.
// Define SPI_SLAVE_RX_FIFO_EN to buffer bytes in an RxFifoDepth-entry FIFO instead of one register.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SyncStages  = 2,
    parameter int RxFifoDepth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                spi_slave_clk_i,
    input  logic                spi_slave_cs_i,
    input  logic                spi_slave_mosi_i,
    output logic [SpiByteW-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                busy_o,
    output logic                overflow_o,
    output logic                frame_err_o
);
    localparam logic SclkIdle = 1'(CPOL);

    if (SyncStages < SpiMinSyncStages) begin : g_bad_sync
        $error("SyncStages below minimum");
    end
    if (RxFifoDepth < 2 || (RxFifoDepth & (RxFifoDepth - 1)) != 0) begin : g_bad_depth
        $error("RxFifoDepth must be a power of two, at least 2");
    end

    logic [SyncStages-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic [SyncStages-1:0] w_sclk_in, w_cs_in, w_mosi_in;
    logic                  r_sclk_hist, r_cs_hist, r_mosi_hist;
    logic                  w_sclk_s, w_cs_s, w_mosi_s, w_sample;
    logic                  r_sample_evt, r_cs_fall_evt, r_cs_rise_evt;

    assign w_sclk_in = {r_sclk_sync[SyncStages-2:0], spi_slave_clk_i};
    assign w_cs_in   = {r_cs_sync[SyncStages-2:0], spi_slave_cs_i};
    assign w_mosi_in = {r_mosi_sync[SyncStages-2:0], spi_slave_mosi_i};

    // Synchronisers reset to the idle bus levels so releasing reset never fakes an edge.
    genvar gi;
    for (gi = 0; gi < SyncStages; gi++) begin : g_sclk_sync
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_sclk_sync[gi] <= SclkIdle;
            else         r_sclk_sync[gi] <= w_sclk_in[gi];
        end
    end
    for (gi = 0; gi < SyncStages; gi++) begin : g_cs_sync
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_cs_sync[gi] <= 1'b1;
            else         r_cs_sync[gi] <= w_cs_in[gi];
        end
    end
    for (gi = 0; gi < SyncStages; gi++) begin : g_mosi_sync
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_mosi_sync[gi] <= 1'b0;
            else         r_mosi_sync[gi] <= w_mosi_in[gi];
        end
    end

    assign w_sclk_s = r_sclk_sync[SyncStages-1];
    assign w_cs_s   = r_cs_sync[SyncStages-1];
    assign w_mosi_s = r_mosi_sync[SyncStages-1];
    assign w_sample = (w_sclk_s ^ r_sclk_hist) &&
                      ((CPHA == 0) ? (w_sclk_s != SclkIdle) : (w_sclk_s == SclkIdle));
    assign busy_o   = ~r_cs_hist;

    // r_mosi_hist lines up with r_sample_evt: both hold the value seen alongside the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_hist   <= SclkIdle;
            r_cs_hist     <= 1'b1;
            r_mosi_hist   <= 1'b0;
            r_sample_evt  <= 1'b0;
            r_cs_fall_evt <= 1'b0;
            r_cs_rise_evt <= 1'b0;
        end else begin
            r_sclk_hist   <= w_sclk_s;
            r_cs_hist     <= w_cs_s;
            r_mosi_hist   <= w_mosi_s;
            r_sample_evt  <= w_sample;
            r_cs_fall_evt <= r_cs_hist & ~w_cs_s;
            r_cs_rise_evt <= ~r_cs_hist & w_cs_s;
        end
    end

    spi_rx_state_e       r_state, w_state_next;
    logic [2:0]          r_bit_cnt, w_cnt_next;
    logic [SpiByteW-2:0] r_shift, w_shift_next;
    logic                w_push, w_frame_err;
    logic                r_push, r_overflow, r_frame_err;
    logic [SpiByteW-1:0] r_push_data;
    logic                w_wr_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cs_fall_evt) begin
                    w_state_next = RECV;
                    w_cnt_next   = '0;
                    w_shift_next = '0;
                end
            end
            RECV: begin
                if (r_cs_rise_evt) begin
                    w_state_next = IDLE;
                    w_frame_err  = (r_bit_cnt != '0);
                    w_cnt_next   = '0;
                    w_shift_next = '0;
                end else if (r_sample_evt) begin
                    w_shift_next = {r_shift[SpiByteW-3:0], r_mosi_hist};
                    w_cnt_next   = r_bit_cnt + 3'd1;
                    w_push       = (r_bit_cnt == 3'd7);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_push      <= w_push;
            if (w_push) begin
                r_push_data <= {r_shift, r_mosi_hist};
            end
            r_overflow  <= r_push & ~w_wr_ready;
            r_frame_err <= w_frame_err;
        end
    end

    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;

`ifdef SPI_SLAVE_RX_FIFO_EN
    spi_rx_fifo #(
        .Width (SpiByteW),
        .Depth (RxFifoDepth)
    ) u_rx_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_data_i  (r_push_data),
        .wr_valid_i (r_push),
        .wr_ready_o (w_wr_ready),
        .rd_data_o  (rx_data_o),
        .rd_valid_o (rx_valid_o),
        .rd_ready_i (rx_ready_i)
    );
`else
    logic                r_hold_valid;
    logic [SpiByteW-1:0] r_hold_data;

    assign w_wr_ready = ~r_hold_valid | rx_ready_i;
    assign rx_valid_o = r_hold_valid;
    assign rx_data_o  = r_hold_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (r_push && w_wr_ready) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= r_push_data;
        end else if (rx_ready_i) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: four instances (one per CPOL/CPHA mode) share CS/MOSI
// and an SCLK that each instance sees with its own idle polarity.
module tb_spi_slave_rx;
    localparam int S = 2;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk_base = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] sclk_m;
    logic [7:0] rx_data [4];
    logic [3:0] rx_valid, busy, ovf, ferr;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_dut
        assign sclk_m[gi] = sclk_base ^ 1'(gi / 2);
        spi_slave_rx #(
            .CPOL        (gi / 2),
            .CPHA        (gi % 2),
            .SyncStages  (S),
            .RxFifoDepth (4)
        ) u_dut (
            .clk_i            (clk),
            .rst_ni           (rst_n),
            .spi_slave_clk_i  (sclk_m[gi]),
            .spi_slave_cs_i   (cs),
            .spi_slave_mosi_i (mosi),
            .rx_data_o        (rx_data[gi]),
            .rx_valid_o       (rx_valid[gi]),
            .rx_ready_i       (ready),
            .busy_o           (busy[gi]),
            .overflow_o       (ovf[gi]),
            .frame_err_o      (ferr[gi])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Consumer ready changes just after the rising edge so it is stable at every sample point.
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    logic [7:0] exp_q [4][$];
    int         ovf_cnt [4];
    int         ferr_cnt [4];
    logic [3:0] prev_stall = '0;
    logic [7:0] prev_data [4];
    int         lat_start = 0;
    bit         lat_armed = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ovf[i])  ovf_cnt[i]++;
                if (ferr[i]) ferr_cnt[i]++;
                if (prev_stall[i]) begin
                    chk($sformatf("hold_valid_m%0d", i), int'(rx_valid[i]), 1);
                    chk($sformatf("hold_data_m%0d", i), int'(rx_data[i]), int'(prev_data[i]));
                end
                if (rx_valid[i] && ready) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("unexpected_byte_m%0d", i), int'(rx_data[i]), -1);
                    end else begin
                        chk($sformatf("data_m%0d", i), int'(rx_data[i]), int'(exp_q[i].pop_front()));
                    end
                    if (i == 0 && lat_armed) begin
                        chk("latency_m0", cyc - lat_start, S + 3);
                        lat_armed = 1'b0;
                    end
                end
                prev_stall[i] = rx_valid[i] && !ready;
                prev_data[i]  = rx_data[i];
            end
        end
    end

    int half = 4;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) exp_q[i].push_back(b);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cs_high();
        wait_cyc(8);
        cs = 1'b1;
        wait_cyc(8);
    endtask

    // MOSI is set with SCLK idle and held until after the trailing edge, which suits every mode.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit arm);
        for (int k = 0; k < nbits; k++) begin
            mosi = b[7-k];
            wait_cyc(half);
            sclk_base = 1'b1;
            if (arm && k == 7) begin
                lat_start = cyc;
                lat_armed = 1'b1;
            end
            wait_cyc(half);
            sclk_base = 1'b0;
            wait_cyc(2);
        end
    endtask

    task automatic check_drained(input string name);
        wait_cyc(40);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_left_m%0d", name, i), exp_q[i].size(), 0);
    endtask

    int ovf_base [4];
    int ferr_base [4];

    task automatic snap_counts();
        for (int i = 0; i < 4; i++) begin
            ovf_base[i]  = ovf_cnt[i];
            ferr_base[i] = ferr_cnt[i];
        end
    endtask

    task automatic check_counts(input string name, input int n_ovf, input int n_ferr);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_ovf_m%0d", name, i), ovf_cnt[i] - ovf_base[i], n_ovf);
            chk($sformatf("%s_ferr_m%0d", name, i), ferr_cnt[i] - ferr_base[i], n_ferr);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_valid"}, int'(rx_valid), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_ovf"}, int'(ovf), 0);
        chk({name, "_ferr"}, int'(ferr), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_data_m%0d", name, i), int'(rx_data[i]), 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ovf_cnt[i]  = 0;
            ferr_cnt[i] = 0;
        end
        wait_cyc(4);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        // Single byte in every mode, latency measured on mode 0.
        ready_mode = 1;
        snap_counts();
        cs_low();
        chk("busy_in_frame", int'(busy), 4'hf);
        expect_byte(8'hA5);
        send_bits(8'hA5, 8, 1'b1);
        cs_high();
        chk("busy_after_frame", int'(busy), 0);
        check_drained("a5");
        chk("latency_seen", int'(lat_armed), 0);
        check_counts("a5", 0, 0);

        // Two bytes in one frame.
        cs_low();
        expect_byte(8'h3C);
        expect_byte(8'hC3);
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hC3, 8, 1'b0);
        cs_high();
        check_drained("3c_c3");

        // Overflow: the consumer stalls while five bytes arrive.
        ready_mode = 0;
        wait_cyc(2);
        snap_counts();
        cs_low();
        for (int b = 1; b <= 5; b++) begin
            if (b <= CAP) expect_byte(8'(b));
            send_bits(8'(b), 8, 1'b0);
        end
        cs_high();
        check_counts("ovf", 5 - CAP, 0);
        chk("ovf_valid_held", int'(rx_valid), 4'hf);
        ready_mode = 1;
        check_drained("ovf");

        // Partial byte then a clean frame.
        snap_counts();
        cs_low();
        send_bits(8'hB6, 5, 1'b0);
        cs_high();
        chk("ferr_busy_low", int'(busy), 0);
        check_counts("ferr", 0, 1);
        cs_low();
        expect_byte(8'h7E);
        send_bits(8'h7E, 8, 1'b0);
        cs_high();
        check_drained("7e");

        // Reset mid-byte with data buffered.
        ready_mode = 0;
        wait_cyc(2);
        cs_low();
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'h22, 8, 1'b0);
        send_bits(8'h33, 3, 1'b0);
        sclk_base = 1'b1;
        wait_cyc(1);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        wait_cyc(2);
        check_outputs_zero("mid_reset");
        cs = 1'b1;
        sclk_base = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(6);
        ready_mode = 1;
        cs_low();
        expect_byte(8'h99);
        send_bits(8'h99, 8, 1'b0);
        cs_high();
        check_drained("after_reset");

        // Randomised frames, bit rates and consumer back-pressure.
        ready_mode = 2;
        snap_counts();
        for (int f = 0; f < 6; f++) begin
            int n;
            n    = $urandom_range(1, 3);
            half = $urandom_range(4, 6);
            cs_low();
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                expect_byte(b);
                send_bits(b, 8, 1'b0);
            end
            cs_high();
        end
        ready_mode = 1;
        check_drained("random");
        check_counts("random", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
